// File: rtl/frame_packer.sv
// Frame packer: buffers a valid-only sample stream in a FWFT FIFO and emits
// fixed-length frames on a ready/valid stream with end-of-frame marking.
module frame_packer #(
    parameter int DATA_W  = 64,
    parameter int FIFO_AW = 9,
    parameter int LEN_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic [31:0]       num_frames,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    input  logic              data_out_ready,
    output logic              data_out_last,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [FIFO_AW:0]  fifo_level,
    output logic [31:0]       frames_sent
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] LVL_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW+1)'(DEPTH);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   level;
    logic [LEN_W-1:0]   len_q, last_idx, in_idx, out_idx;
    logic [31:0]        nf_q, in_frames, sent;
    logic               ovf_q, done_q;
    logic               start, full, in_quota, push, drop;
    logic               out_valid, pop, out_wrap, out_last, final_xfer;

    // A programmed length of 0 behaves as a length of 1
    assign last_idx   = (len_q == '0) ? '0 : len_q - LEN_ONE;
    assign start      = (state == IDLE) && enable;
    assign full       = (level == LVL_FULL);
    assign in_quota   = (nf_q != 32'd0) && (in_frames == nf_q);
    assign push       = (state == RUN) && data_in_valid && !full && !in_quota;
    assign drop       = (state == RUN) && data_in_valid && full && !in_quota;
    assign out_valid  = ((state == RUN) || (state == DRAIN)) && (level != '0);
    assign pop        = out_valid && data_out_ready;
    assign out_wrap   = (out_idx == last_idx);
    assign out_last   = out_valid &&
                        (out_wrap || ((state == DRAIN) && (level == LVL_ONE)));
    assign final_xfer = pop && out_wrap && (nf_q != 32'd0) &&
                        (sent + 32'd1 == nf_q);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN: begin
                if (final_xfer)   state_nxt = DONE;
                else if (!enable) state_nxt = DRAIN;
            end
            DRAIN:   if (level == '0) state_nxt = IDLE;
            DONE:    if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        data_out_valid = out_valid;
        data_out       = out_valid ? mem[rd_ptr] : '0;
        data_out_last  = out_last;
        busy           = (state != IDLE);
        done           = done_q;
        overflow       = ovf_q;
        fifo_level     = level;
        frames_sent    = sent;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (reset || start) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            in_idx    <= '0;
            out_idx   <= '0;
            in_frames <= '0;
            sent      <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            len_q     <= reset ? '0 : frame_len;
            nf_q      <= reset ? '0 : num_frames;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (in_idx == last_idx) begin
                    in_idx    <= '0;
                    in_frames <= in_frames + 32'd1;
                end else begin
                    in_idx <= in_idx + LEN_ONE;
                end
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                out_idx <= out_last ? '0 : out_idx + LEN_ONE;
                if (out_wrap) sent <= sent + 32'd1;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
            if (drop) ovf_q <= 1'b1;
            if ((state == RUN) && (state_nxt == DONE)) done_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_packer.sv
// Scoreboard bench for frame_packer: directed stimulus pushes expected words,
// a negedge monitor pops and compares every transfer.
module tb_frame_packer;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] frame_len;
    logic [31:0] num_frames;
    logic [63:0] data_in;
    logic        data_in_valid;
    logic [63:0] data_out;
    logic        data_out_valid;
    logic        data_out_ready;
    logic        data_out_last;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [9:0]  fifo_level;
    logic [31:0] frames_sent;

    frame_packer dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .frame_len     (frame_len),
        .num_frames    (num_frames),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .data_out_last (data_out_last),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .fifo_level    (fifo_level),
        .frames_sent   (frames_sent)
    );

    typedef struct packed {
        logic [63:0] d;
        logic        l;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   nout   = 0;
    logic tog    = 1'b0;

    logic        prev_stall = 1'b0;
    logic [63:0] prev_d;
    logic        prev_l;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_data", data_out, prev_d);
                chk("stall_last", {63'd0, data_out_last}, {63'd0, prev_l});
            end
            if (data_out_valid && data_out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h required=none",
                             data_out);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", data_out, e.d);
                    chk("out_last", {63'd0, data_out_last}, {63'd0, e.l});
                end
                nout++;
            end
            prev_stall = data_out_valid && !data_out_ready;
            prev_d     = data_out;
            prev_l     = data_out_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (tog) data_out_ready = !data_out_ready;
    endtask

    task automatic send(input logic [63:0] v);
        data_in       = v;
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
    endtask

    task automatic expect_word(input logic [63:0] v, input logic l);
        exp_t e;
        e.d = v;
        e.l = l;
        sb.push_back(e);
    endtask

    task automatic start_run(input logic [15:0] len, input logic [31:0] nf);
        frame_len  = len;
        num_frames = nf;
        enable     = 1'b1;
        tick();
    endtask

    task automatic wait_level0(input string name, input int bound);
        for (int i = 0; i < bound && fifo_level != 0; i++) tick();
        chk(name, {54'd0, fifo_level}, 64'd0);
    endtask

    task automatic wait_idle(input string name);
        enable = 1'b0;
        for (int i = 0; i < 1200 && busy; i++) tick();
        chk(name, {63'd0, busy}, 64'd0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, {63'd0, data_out_valid}, 64'd0);
        chk({tag, "_last"},  {63'd0, data_out_last}, 64'd0);
        chk({tag, "_data"},  data_out, 64'd0);
        chk({tag, "_busy"},  {63'd0, busy}, 64'd0);
        chk({tag, "_done"},  {63'd0, done}, 64'd0);
        chk({tag, "_ovf"},   {63'd0, overflow}, 64'd0);
        chk({tag, "_level"}, {54'd0, fifo_level}, 64'd0);
        chk({tag, "_frames"}, {32'd0, frames_sent}, 64'd0);
    endtask

    initial begin
        int n0;
        reset          = 1'b1;
        enable         = 1'b0;
        frame_len      = '0;
        num_frames     = '0;
        data_in        = '0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b0;
        repeat (3) tick();
        chk_zero_outputs("reset");
        reset = 1'b0;
        tick();

        // Frame marking with quota
        data_out_ready = 1'b1;
        start_run(16'd4, 32'd2);
        for (int i = 1; i <= 8; i++) begin
            expect_word(64'(i), (i % 4) == 0);
            send(64'(i));
        end
        tick();
        chk("t1_done", {63'd0, done}, 64'd1);
        chk("t1_frames", {32'd0, frames_sent}, 64'd2);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 3; i++) send(64'hEEEE);
        chk("t1_ovf", {63'd0, overflow}, 64'd0);
        chk("t1_level", {54'd0, fifo_level}, 64'd0);
        enable = 1'b0;
        tick();
        chk("t1_idle_busy", {63'd0, busy}, 64'd0);
        chk("t1_done_hold", {63'd0, done}, 64'd1);

        // Quota reached while stalled: extra samples ignored, no overflow
        data_out_ready = 1'b0;
        start_run(16'd2, 32'd1);
        chk("q_done_clr", {63'd0, done}, 64'd0);
        expect_word(64'h21, 1'b0);
        expect_word(64'h22, 1'b1);
        for (int i = 1; i <= 4; i++) send(64'h20 + 64'(i));
        chk("q_level", {54'd0, fifo_level}, 64'd2);
        chk("q_ovf", {63'd0, overflow}, 64'd0);
        data_out_ready = 1'b1;
        for (int i = 0; i < 10 && !done; i++) tick();
        chk("q_done", {63'd0, done}, 64'd1);
        chk("q_frames", {32'd0, frames_sent}, 64'd1);
        enable = 1'b0;
        tick();

        // Backpressure overflow
        data_out_ready = 1'b0;
        start_run(16'd16, 32'd0);
        for (int i = 0; i < 512; i++) begin
            expect_word(64'hB000 + 64'(i), (i % 16) == 15);
            send(64'hB000 + 64'(i));
        end
        chk("ovf_level_full", {54'd0, fifo_level}, 64'd512);
        chk("ovf_before", {63'd0, overflow}, 64'd0);
        send(64'hDEAD);
        chk("ovf_after", {63'd0, overflow}, 64'd1);
        chk("ovf_level_hold", {54'd0, fifo_level}, 64'd512);
        n0 = nout;
        data_out_ready = 1'b1;
        wait_level0("ovf_drain", 600);
        chk("ovf_count", 64'(nout - n0), 64'd512);
        chk("ovf_frames", {32'd0, frames_sent}, 64'd32);
        wait_idle("ovf_idle");

        // Ready toggling every cycle
        data_out_ready = 1'b0;
        start_run(16'd3, 32'd0);
        tog = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            expect_word(64'hC00 + 64'(i), (i % 3) == 0);
            send(64'hC00 + 64'(i));
        end
        wait_level0("tog_drain", 50);
        tog = 1'b0;
        chk("tog_frames", {32'd0, frames_sent}, 64'd3);
        wait_idle("tog_idle");

        // Truncated frame in DRAIN
        data_out_ready = 1'b0;
        start_run(16'd4, 32'd0);
        for (int i = 1; i <= 6; i++) begin
            expect_word(64'hD0 + 64'(i), (i == 4) || (i == 6));
            send(64'hD0 + 64'(i));
        end
        enable = 1'b0;
        tick();
        chk("tr_busy_drain", {63'd0, busy}, 64'd1);
        chk("tr_level", {54'd0, fifo_level}, 64'd6);
        data_out_ready = 1'b1;
        for (int i = 0; i < 20 && fifo_level != 0; i++) tick();
        chk("tr_empty", {54'd0, fifo_level}, 64'd0);
        chk("tr_busy_empty", {63'd0, busy}, 64'd1);
        tick();
        chk("tr_busy_fall", {63'd0, busy}, 64'd0);
        chk("tr_frames", {32'd0, frames_sent}, 64'd1);

        // frame_len = 0 behaves as 1
        data_out_ready = 1'b1;
        start_run(16'd0, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            expect_word(64'hE0 + 64'(i), 1'b1);
            send(64'hE0 + 64'(i));
        end
        tick();
        chk("len0_frames", {32'd0, frames_sent}, 64'd5);
        wait_idle("len0_idle");

        // Reset in the middle of a frame, then a fresh frame
        data_out_ready = 1'b0;
        start_run(16'd4, 32'd0);
        send(64'hF1);
        send(64'hF2);
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        chk_zero_outputs("mid_reset");
        reset = 1'b0;
        tick();
        data_out_ready = 1'b1;
        start_run(16'd4, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            expect_word(64'hF10 + 64'(i), i == 4);
            send(64'hF10 + 64'(i));
        end
        tick();
        chk("rst_frames", {32'd0, frames_sent}, 64'd1);
        wait_idle("rst_idle");

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
